// File: rtl/minisys_int_pkg.sv
// ---------------------------------------------------------------------------
// minisys_int_pkg
// Shared definitions for the MiniSys interrupt controller: IO register
// offsets, interrupt source indices, the source count and the controller
// FSM state encoding (the encoding is visible to software through STATUS).
// Ports: none (package).
// ---------------------------------------------------------------------------
package minisys_int_pkg;

    localparam int NUM_SRC = 6;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd2;
    localparam logic [2:0] ADDR_PENDING = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd6;

    localparam int SRC_INT0 = 0;
    localparam int SRC_INT1 = 1;
    localparam int SRC_KEY  = 2;
    localparam int SRC_CTC  = 3;
    localparam int SRC_UART = 4;
    localparam int SRC_WDT  = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } intState_e;

endpackage

// File: rtl/minisys_int_prio.sv
// ---------------------------------------------------------------------------
// minisys_int_prio
// Combinational fixed-priority encoder: the lowest set request index wins,
// so int0 has the highest priority.
// Ports:
//   req_i   [NUM_SRC-1:0]  active requests (pending & enabled)
//   idx_o   [2:0]          index of the winning request
//   valid_o                at least one request is active
// ---------------------------------------------------------------------------
module minisys_int_prio
    import minisys_int_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    output logic [2:0]         idx_o,
    output logic               valid_o
);

    // Scanning from the top index down lets the lowest set bit overwrite
    // any higher one, which gives the fixed priority order.
    always_comb begin
        idx_o   = 3'd0;
        valid_o = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = 3'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/minisys_int_ctrl.sv
// ---------------------------------------------------------------------------
// minisys_int_ctrl
// Six-source interrupt controller for the MiniSys CPU. Raw sources are
// synchronized, collected in PENDING, masked by ENABLE and the global
// enable GIE, and the highest-priority request is presented on irq/irq_vec.
// A three-state FSM (IDLE -> REQ -> SERVICE) tracks the handshake with
// the CPU via irq_ack and eret.
//
// Configuration macro: MINISYS_INT_EDGE_EN
//   defined   : PENDING bits set on synchronized rising edges, cleared by
//               write-1 to PENDING or by irq_ack of that source.
//   undefined : PENDING mirrors the synchronized sources (level mode); the
//               ISR must clear the source itself.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   int_src[5:0]      raw sources: int0, int1, key, ctc, uart, wdt
//   int_cs, addr      IO chip select and register offset
//   IORead, IOWrite   IO strobes
//   wdata[15:0]       IO write data
//   rdata[15:0]       IO read data (combinational)
//   irq               registered interrupt request to the CPU
//   irq_vec[2:0]      index of the requested / in-service source
//   irq_ack, eret     CPU acknowledge and return-from-interrupt pulses
// ---------------------------------------------------------------------------
module minisys_int_ctrl
    import minisys_int_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  int_src,
    input  logic                int_cs,
    input  logic [2:0]          addr,
    input  logic                IORead,
    input  logic                IOWrite,
    input  logic [15:0]         wdata,
    output logic [15:0]         rdata,
    output logic                irq,
    output logic [2:0]          irq_vec,
    input  logic                irq_ack,
    input  logic                eret
);

    logic [NUM_SRC-1:0] sync1_q, sync2_q;
    logic               gie_q;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    intState_e          state_q, state_d;
    logic [2:0]         vec_q, vec_d;
    logic               irq_q, irq_d;
    logic [2:0]         winIdx;
    logic               winValid;
    logic               ctrlWr, enableWr;
    logic               unusedWdata;

    assign ctrlWr      = int_cs && IOWrite && (addr == ADDR_CTRL);
    assign enableWr    = int_cs && IOWrite && (addr == ADDR_ENABLE);
    assign unusedWdata = ^wdata[15:NUM_SRC];

    // Two-flop synchronizer for the asynchronous sources.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= int_src;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gie_q    <= 1'b0;
            enable_q <= '0;
        end else begin
            if (ctrlWr)   gie_q    <= wdata[0];
            if (enableWr) enable_q <= wdata[NUM_SRC-1:0];
        end
    end

`ifdef MINISYS_INT_EDGE_EN
    logic [NUM_SRC-1:0] sync3_q;
    logic [NUM_SRC-1:0] riseEvt, clrMask;
    logic               pendingWr, ackTaken;

    always_ff @(posedge clock) begin
        if (reset) sync3_q <= '0;
        else       sync3_q <= sync2_q;
    end

    assign pendingWr = int_cs && IOWrite && (addr == ADDR_PENDING);
    assign ackTaken  = (state_q == ST_REQ) && irq_ack;
    assign riseEvt   = sync2_q & ~sync3_q;

    // Clears are applied first and the new edges OR-ed in afterwards, so a
    // set arriving together with a clear on the same bit is never lost.
    always_comb begin
        clrMask = '0;
        if (pendingWr) clrMask = clrMask | wdata[NUM_SRC-1:0];
        if (ackTaken)  clrMask = clrMask | (NUM_SRC'(1) << vec_q);
        pending_d = (pending_q & ~clrMask) | riseEvt;
    end
`else
    always_comb begin
        pending_d = sync2_q;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    minisys_int_prio uPrio (
        .req_i   (pending_q & enable_q),
        .idx_o   (winIdx),
        .valid_o (winValid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            irq_q   <= irq_d;
        end
    end

    // irq is registered from "staying in REQ", so it rises one cycle after
    // REQ is entered and falls on the same edge that leaves REQ. An ack
    // is checked before the withdrawal conditions so that it wins.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        irq_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gie_q && winValid) begin
                    state_d = ST_REQ;
                    vec_d   = winIdx;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d = ST_SERVICE;
                end else if (!gie_q || !pending_q[vec_q] || !enable_q[vec_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    irq_d = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (eret) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata = 16'h0000;
        if (int_cs && IORead) begin
            case (addr)
                ADDR_CTRL:    rdata = {15'd0, gie_q};
                ADDR_ENABLE:  rdata = {10'd0, enable_q};
                ADDR_PENDING: rdata = {10'd0, pending_q};
                ADDR_STATUS:  rdata = {11'd0, state_q, vec_q};
                default:      rdata = 16'h0000;
            endcase
        end
    end

    assign irq     = irq_q;
    assign irq_vec = vec_q;

endmodule

// File: tb/tb_minisys_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_minisys_int_ctrl
// Self-checking bench for minisys_int_ctrl: a table of register-access
// vectors followed by hand-written interrupt handshake sequences. Expected
// values that differ between edge mode (MINISYS_INT_EDGE_EN) and level mode
// are selected from the build mode.
// ---------------------------------------------------------------------------
module tb_minisys_int_ctrl;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_ENABLE  = 3'd2;
    localparam logic [2:0] A_PENDING = 3'd4;
    localparam logic [2:0] A_STATUS  = 3'd6;

`ifdef MINISYS_INT_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  int_src;
    logic        int_cs;
    logic [2:0]  addr;
    logic        IORead;
    logic        IOWrite;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        irq;
    logic [2:0]  irq_vec;
    logic        irq_ack;
    logic        eret;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic        wr;
        logic        wcs;
        logic        rcs;
        logic [2:0]  a;
        logic [15:0] wd;
        logic [15:0] exp;
    } ioVec_t;

    ioVec_t vecs [13];

    minisys_int_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .int_src (int_src),
        .int_cs  (int_cs),
        .addr    (addr),
        .IORead  (IORead),
        .IOWrite (IOWrite),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack),
        .eret    (eret)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        else
            passed++;
    endtask

    task automatic ioWrite(input logic cs, input logic [2:0] a, input logic [15:0] d);
        int_cs  = cs;
        IOWrite = 1'b1;
        addr    = a;
        wdata   = d;
        tick(1);
        int_cs  = 1'b0;
        IOWrite = 1'b0;
        addr    = 3'd0;
        wdata   = 16'h0000;
    endtask

    task automatic ioRead(input logic cs, input logic [2:0] a, output logic [15:0] d);
        int_cs = cs;
        IORead = 1'b1;
        addr   = a;
        #1;
        d      = rdata;
        int_cs = 1'b0;
        IORead = 1'b0;
        addr   = 3'd0;
    endtask

    task automatic checkReg(input string name, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] v;
        ioRead(1'b1, a, v);
        checkOutput(name, v, exp);
    endtask

    task automatic applyStimulus(input int idx, input ioVec_t v);
        logic [15:0] rd;
        if (v.wr) ioWrite(v.wcs, v.a, v.wd);
        ioRead(v.rcs, v.a, rd);
        checkOutput($sformatf("regvec%0d", idx), rd, v.exp);
    endtask

    task automatic pulseAck();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulseEret();
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
    endtask

    initial begin
        //           wr    wcs   rcs   addr       wdata     expected
        vecs[0]  = '{1'b1, 1'b1, 1'b1, A_CTRL,    16'hFFFF, 16'h0001};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, A_ENABLE,  16'hFFC5, 16'h0005};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 3'd1,      16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 3'd3,      16'h0000, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 3'd5,      16'h0000, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 3'd7,      16'h0000, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, A_CTRL,    16'h0000, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, A_STATUS,  16'h0000, 16'h0000};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, A_PENDING, 16'h003F, 16'h0000};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, A_STATUS,  16'hFFFF, 16'h0000};
        vecs[10] = '{1'b1, 1'b1, 1'b1, A_ENABLE,  16'h0000, 16'h0000};
        vecs[11] = '{1'b1, 1'b1, 1'b1, A_CTRL,    16'h0000, 16'h0000};
        vecs[12] = '{1'b1, 1'b0, 1'b1, A_ENABLE,  16'h003F, 16'h0000};

        reset   = 1'b1;
        int_src = 6'd0;
        int_cs  = 1'b0;
        addr    = 3'd0;
        IORead  = 1'b0;
        IOWrite = 1'b0;
        wdata   = 16'h0000;
        irq_ack = 1'b0;
        eret    = 1'b0;
        tick(2);
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_irq", 16'(irq), 16'h0000);
        checkOutput("rst_vec", 16'(irq_vec), 16'h0000);
        checkReg("rst_status", A_STATUS, 16'h0000);

        $display("[TB] register map vectors");
        for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);

        $display("[TB] single source latency and handshake");
        ioWrite(1'b1, A_ENABLE, 16'h003F);
        ioWrite(1'b1, A_CTRL, 16'h0001);
        int_src = 6'b001000;
        tick(4);
        checkOutput("lat_cycle4_irq", 16'(irq), 16'h0000);
        tick(1);
        checkOutput("lat_cycle5_irq", 16'(irq), 16'h0001);
        checkOutput("lat_vec", 16'(irq_vec), 16'h0003);
        checkReg("req_status", A_STATUS, 16'h000B);
        pulseAck();
        int_src = 6'd0;
        checkOutput("svc_irq", 16'(irq), 16'h0000);
        checkReg("svc_status", A_STATUS, 16'h0013);
        checkReg("ack_pending", A_PENDING, EDGE ? 16'h0000 : 16'h0008);
        tick(3);
        checkReg("svc_pending_clear", A_PENDING, 16'h0000);
        pulseEret();
        checkReg("eret_status", A_STATUS, 16'h0003);
        tick(3);
        checkOutput("idle_irq", 16'(irq), 16'h0000);

        $display("[TB] simultaneous sources");
        int_src = 6'b010010;
        tick(5);
        checkOutput("prio_irq", 16'(irq), 16'h0001);
        checkOutput("prio_vec", 16'(irq_vec), 16'h0001);
        pulseAck();
        int_src = 6'b010000;
        tick(3);
        pulseEret();
        tick(2);
        checkOutput("second_irq", 16'(irq), 16'h0001);
        checkOutput("second_vec", 16'(irq_vec), 16'h0004);
        pulseEret();
        checkReg("eret_in_req_status", A_STATUS, 16'h000C);
        checkOutput("eret_in_req_irq", 16'(irq), 16'h0001);
        pulseAck();
        int_src = 6'd0;
        tick(3);
        pulseEret();
        tick(3);
        checkOutput("no_third_irq", 16'(irq), 16'h0000);

        $display("[TB] withdrawal by ENABLE");
        int_src = 6'b000100;
        tick(5);
        checkOutput("wd_irq_before", 16'(irq), 16'h0001);
        checkOutput("wd_vec", 16'(irq_vec), 16'h0002);
        ioWrite(1'b1, A_ENABLE, 16'h003B);
        tick(1);
        checkOutput("wd_irq_after", 16'(irq), 16'h0000);
        checkReg("wd_status", A_STATUS, 16'h0002);
        checkReg("wd_pending", A_PENDING, 16'h0004);
        int_src = 6'd0;
        ioWrite(1'b1, A_PENDING, 16'h0004);
        tick(3);
        checkReg("wd_pending_cleared", A_PENDING, 16'h0000);
        ioWrite(1'b1, A_ENABLE, 16'h003F);

        $display("[TB] pending set against write-1 clear");
        ioWrite(1'b1, A_CTRL, 16'h0000);
        int_src = 6'b000001;
        tick(2);
        ioWrite(1'b1, A_PENDING, 16'h0001);
        checkReg("set_wins", A_PENDING, 16'h0001);
        ioWrite(1'b1, A_PENDING, 16'h0001);
        checkReg("w1c", A_PENDING, EDGE ? 16'h0000 : 16'h0001);
        int_src = 6'd0;
        tick(3);
        ioWrite(1'b1, A_PENDING, 16'h003F);
        checkReg("w1c_final", A_PENDING, 16'h0000);

        $display("[TB] reset during service");
        ioWrite(1'b1, A_CTRL, 16'h0001);
        int_src = 6'b100000;
        tick(5);
        checkOutput("wdt_irq", 16'(irq), 16'h0001);
        checkOutput("wdt_vec", 16'(irq_vec), 16'h0005);
        pulseAck();
        checkReg("wdt_svc_status", A_STATUS, 16'h0015);
        reset   = 1'b1;
        int_src = 6'd0;
        tick(1);
        reset = 1'b0;
        checkReg("rst_svc_status", A_STATUS, 16'h0000);
        checkOutput("rst_svc_irq", 16'(irq), 16'h0000);
        checkOutput("rst_svc_vec", 16'(irq_vec), 16'h0000);
        checkReg("rst_svc_ctrl", A_CTRL, 16'h0000);
        checkReg("rst_svc_enable", A_ENABLE, 16'h0000);
        checkReg("rst_svc_pending", A_PENDING, 16'h0000);
        tick(3);
        checkReg("rst_svc_residue", A_PENDING, 16'h0000);

        $display("[TB] held source through ack and eret");
        ioWrite(1'b1, A_ENABLE, 16'h003F);
        ioWrite(1'b1, A_CTRL, 16'h0001);
        int_src = 6'b000001;
        tick(5);
        checkOutput("hold_irq", 16'(irq), 16'h0001);
        checkOutput("hold_vec", 16'(irq_vec), 16'h0000);
        ioWrite(1'b1, A_CTRL, 16'h0000);
        pulseAck();
        checkReg("ack_wins_status", A_STATUS, 16'h0010);
        ioWrite(1'b1, A_CTRL, 16'h0001);
        pulseEret();
        tick(2);
        checkOutput("rereq_irq", 16'(irq), EDGE ? 16'h0000 : 16'h0001);
        checkOutput("rereq_vec", 16'(irq_vec), 16'h0000);
        pulseAck();
        int_src = 6'd0;
        tick(4);
        pulseEret();
        tick(5);
        checkOutput("dropped_irq", 16'(irq), 16'h0000);
        checkReg("dropped_status", A_STATUS, 16'h0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
